// File: rtl/qea_state_readout.sv
// Purpose: sweeps the QEA state RAM after completion, squares every amplitude and accumulates <Z_k> plus total probability.
// Latency: the word at address j reaches the accumulators RD_LATENCY+4 cycles after it is issued; o_done follows address W-1 the same way.
// Backpressure: none; one read per cycle, requests arriving while busy are dropped.
module qea_state_readout #(
    parameter int PE_NUM           = 4,
    parameter int PE_NUM_WIDTH     = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int RD_LATENCY       = 1,
    parameter int ACC_WIDTH        = 40
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_target_qbit,
    output logic                                 o_state_ena,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic signed [ACC_WIDTH-1:0]          o_expval,
    output logic [ACC_WIDTH-1:0]                 o_prob_sum
);

    // Width of a global amplitude index {word address, lane}.
    localparam int IDX_W = STATE_ADDR_WIDTH + PE_NUM_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                        r_state;
    logic [MAX_QBIT_WIDTH-1:0]     r_nq;
    logic [MAX_QBIT_WIDTH-1:0]     r_tgt;
    logic [STATE_ADDR_WIDTH-1:0]   r_last_addr;

    // Issue-side tags that travel alongside the RAM read latency.
    logic                          r_tag_vld  [RD_LATENCY];
    logic                          r_tag_last [RD_LATENCY];
    logic [STATE_ADDR_WIDTH-1:0]   r_tag_addr [RD_LATENCY];

    // Capture stage.
    logic                          r_cap_vld;
    logic                          r_cap_last;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0] r_cap_dat;
    logic [PE_NUM-1:0]             r_cap_neg;
    logic [PE_NUM-1:0]             r_cap_en;

    // Square stage.
    logic                          r_sq_vld;
    logic                          r_sq_last;
    logic [PE_NUM-1:0]             r_sq_neg;
    logic signed [ACC_WIDTH-1:0]   r_sq [PE_NUM];

    // Lane-sum stage.
    logic                          r_sum_vld;
    logic                          r_sum_last;
    logic signed [ACC_WIDTH-1:0]   r_sum_exp;
    logic [ACC_WIDTH-1:0]          r_sum_prob;

    logic                          w_bad_req;
    logic [STATE_ADDR_WIDTH-1:0]   w_last_addr;
    logic [PE_NUM-1:0]             w_lane_neg;
    logic [PE_NUM-1:0]             w_lane_en;
    logic signed [STATE_DATA_WIDTH-1:0] w_re [PE_NUM];
    logic signed [STATE_DATA_WIDTH-1:0] w_im [PE_NUM];
    logic signed [ACC_WIDTH-1:0]   w_sq [PE_NUM];
    logic signed [ACC_WIDTH-1:0]   w_sum_exp;
    logic [ACC_WIDTH-1:0]          w_sum_prob;

    // Request check and last word address (W-1); fewer qubits than lanes still needs one word.
    always_comb begin
        w_bad_req = (i_target_qbit >= i_qbit_num) || (int'(i_qbit_num) > IDX_W);
        if (i_qbit_num >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
            w_last_addr = STATE_ADDR_WIDTH'((32'd1 << (i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH))) - 32'd1);
        else
            w_last_addr = '0;
    end

    // Control FSM: accept/reject, address issue, wait for the last word to drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_nq          <= '0;
            r_tgt         <= '0;
            r_last_addr   <= '0;
            o_state_ena   <= 1'b0;
            o_state_addra <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_nq        <= i_qbit_num;
                        r_tgt       <= i_target_qbit;
                        r_last_addr <= w_last_addr;
                        if (w_bad_req) begin
                            o_err <= 1'b1;
                        end else begin
                            r_state       <= S_ISSUE;
                            o_busy        <= 1'b1;
                            o_state_ena   <= 1'b1;
                            o_state_addra <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (o_state_addra == r_last_addr) begin
                        o_state_ena   <= 1'b0;
                        o_state_addra <= '0;
                        r_state       <= S_DRAIN;
                    end else begin
                        o_state_addra <= o_state_addra + STATE_ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    // The final word's lane sum enters the accumulators on this edge.
                    if (r_sum_vld && r_sum_last) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Delay the issued address/valid by the RAM read latency so they line up with i_state_dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_tag_vld[i]  <= 1'b0;
                r_tag_last[i] <= 1'b0;
                r_tag_addr[i] <= '0;
            end
        end else begin
            r_tag_vld[0]  <= o_state_ena;
            r_tag_last[0] <= o_state_ena && (o_state_addra == r_last_addr);
            r_tag_addr[0] <= o_state_addra;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
            end
        end
    end

    // Per-lane sign (bit k of the global index) and lane enable (index < 2^n).
    always_comb begin
        for (int p = 0; p < PE_NUM; p++) begin
            w_lane_neg[p] = |(({r_tag_addr[RD_LATENCY-1], PE_NUM_WIDTH'(p)} >> r_tgt) & IDX_W'(1));
            w_lane_en[p]  = (r_nq >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) ||
                            ((PE_NUM_WIDTH'(p) >> r_nq) == '0);
        end
    end

    // Capture the RAM word together with its lane sign/enable masks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_vld  <= 1'b0;
            r_cap_last <= 1'b0;
            r_cap_dat  <= '0;
            r_cap_neg  <= '0;
            r_cap_en   <= '0;
        end else begin
            r_cap_vld  <= r_tag_vld[RD_LATENCY-1];
            r_cap_last <= r_tag_vld[RD_LATENCY-1] && r_tag_last[RD_LATENCY-1];
            r_cap_dat  <= i_state_dout;
            r_cap_neg  <= w_lane_neg;
            r_cap_en   <= w_lane_en;
        end
    end

    // |a|^2 per lane: full-width signed squares, each floored back to the amplitude scaling.
    always_comb begin
        for (int p = 0; p < PE_NUM; p++) begin
            w_re[p] = STATE_DATA_WIDTH'($signed(r_cap_dat[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: DATA_WIDTH]));
            w_im[p] = STATE_DATA_WIDTH'($signed(r_cap_dat[(PE_NUM-p)*STATE_DATA_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH]));
            if (r_cap_en[p])
                w_sq[p] = ACC_WIDTH'(((w_re[p] * w_re[p]) >>> NUM_FRAC_BIT) +
                                     ((w_im[p] * w_im[p]) >>> NUM_FRAC_BIT));
            else
                w_sq[p] = '0;
        end
    end

    // Register the lane squares.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq_vld  <= 1'b0;
            r_sq_last <= 1'b0;
            r_sq_neg  <= '0;
            for (int p = 0; p < PE_NUM; p++) r_sq[p] <= '0;
        end else begin
            r_sq_vld  <= r_cap_vld;
            r_sq_last <= r_cap_last;
            r_sq_neg  <= r_cap_neg;
            for (int p = 0; p < PE_NUM; p++) r_sq[p] <= w_sq[p];
        end
    end

    // Signed and unsigned sums across the lanes of one word.
    always_comb begin
        w_sum_exp  = '0;
        w_sum_prob = '0;
        for (int p = 0; p < PE_NUM; p++) begin
            w_sum_prob = w_sum_prob + r_sq[p];
            if (r_sq_neg[p])
                w_sum_exp = w_sum_exp - r_sq[p];
            else
                w_sum_exp = w_sum_exp + r_sq[p];
        end
    end

    // Register the per-word sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_vld  <= 1'b0;
            r_sum_last <= 1'b0;
            r_sum_exp  <= '0;
            r_sum_prob <= '0;
        end else begin
            r_sum_vld  <= r_sq_vld;
            r_sum_last <= r_sq_last;
            r_sum_exp  <= w_sum_exp;
            r_sum_prob <= w_sum_prob;
        end
    end

    // Accumulators double as the result outputs; cleared by any start taken in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_expval   <= '0;
            o_prob_sum <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            o_expval   <= '0;
            o_prob_sum <= '0;
        end else if (r_sum_vld) begin
            o_expval   <= o_expval + r_sum_exp;
            o_prob_sum <= o_prob_sum + r_sum_prob;
        end
    end

endmodule

// File: doc/qea_state_readout.md
Name: qea_state_readout

Overview:
- Downstream consumer of the QEA engine's final state vector.
- After QEA asserts o_complete, this block sweeps the QEA state RAM read port and squares every amplitude. It accumulates the Pauli-Z expectation value <Z_k> of one selected qubit, plus the total probability used as a norm check.
- Its result is the scalar used by the parameter-shift gradient logic.

Parameters:
- PE_NUM, 4, amplitudes per state RAM word (lanes)
- PE_NUM_WIDTH, 2, log2(PE_NUM)
- DATA_WIDTH, 32, width of one real or imaginary component
- STATE_DATA_WIDTH, 64, one complex amplitude: {real[63:32], imag[31:0]}
- STATE_ADDR_WIDTH, 16, state RAM word address width
- MAX_QBIT_WIDTH, 6, width of the qubit-count and qubit-index fields
- NUM_FRAC_BIT, 30, fractional bits of the signed fixed-point amplitude format
- RD_LATENCY, 1, state RAM read latency in cycles (1..3)
- ACC_WIDTH, 40, signed accumulator and result width

Ports:
- clk, in, 1, single clock; all logic on the rising edge
- rst, in, 1, synchronous active-high reset
- i_start, in, 1, single-cycle pulse that starts one sweep
- i_qbit_num, in, MAX_QBIT_WIDTH, number of qubits n, sampled with i_start
- i_target_qbit, in, MAX_QBIT_WIDTH, qubit index k for <Z_k>, sampled with i_start
- o_state_ena, out, 1, read enable to the QEA state port
- o_state_addra, out, STATE_ADDR_WIDTH, read word address
- i_state_dout, in, PE_NUM*STATE_DATA_WIDTH, QEA o_state_dout
- o_busy, out, 1, high from the cycle after i_start is accepted until o_done
- o_done, out, 1, one-cycle pulse; results are valid
- o_err, out, 1, one-cycle pulse; the request was rejected
- o_expval, out, ACC_WIDTH signed, sum over amplitudes of sign*|a|^2, same fractional scaling (2^NUM_FRAC_BIT = 1.0)
- o_prob_sum, out, ACC_WIDTH unsigned, sum of |a|^2

Behaviour:
- Reset: all outputs 0, FSM to IDLE, pipeline valid bits cleared, accumulators cleared. Reset mid-sweep aborts with no o_done or o_err.
- Lane mapping: lane p occupies bits [(PE_NUM-p)*64-1 -: 64], so the most-significant 64 bits are lane 0. The global amplitude index is addr*PE_NUM + p.
- Word count: W = 2^n / PE_NUM. If n < PE_NUM_WIDTH, then W = 1 and lanes with index >= 2^n contribute 0.
- Sign rule: bit k of the global index = 0 gives +|a|^2; bit k = 1 gives -|a|^2.
- Square: re*re and im*im are full 64-bit signed products, each arithmetic-shifted right by NUM_FRAC_BIT (floor). |a|^2 is their sum, sign-extended to ACC_WIDTH. No saturation; ACC_WIDTH covers the worst case.
- FSM states IDLE -> ISSUE -> DRAIN -> IDLE.
  - IDLE: on i_start, latch n and k, clear the accumulators. If k >= n or n > STATE_ADDR_WIDTH+PE_NUM_WIDTH, pulse o_err the next cycle and stay in IDLE. Otherwise go to ISSUE.
  - ISSUE: drive one address per cycle with o_state_ena=1. Address j is driven during cycle j+1, where cycle 0 is the edge that sampled i_start. After address W-1, go to DRAIN with ena=0.
  - DRAIN: wait until the pipeline valid shift register is empty, then pulse o_done and return to IDLE.
- Pipeline timing for address j:
  - i_state_dout is captured in cycle j+1+RD_LATENCY.
  - Squares are registered at j+2+RD_LATENCY.
  - The signed lane sum is registered at j+3+RD_LATENCY.
  - The accumulators update at j+4+RD_LATENCY.
- o_done is high in cycle W+3+RD_LATENCY. o_expval and o_prob_sum hold the final values from that cycle until the next accepted i_start.
- i_start while o_busy is ignored. i_start in the same cycle as rst is ignored.
- o_busy stays 0 for a rejected request.

Test Plan:
- n=3, k=0; word0 lane0 = 64'h40000000_00000000, rest 0; RD_LATENCY=1 -> o_done at cycle 6; o_expval = 2^30; o_prob_sum = 2^30; address sequence 0,1.
- n=3, k=0; amplitude index 1 (word0 lane1) = 1.0 -> o_expval = -2^30; o_prob_sum = 2^30.
- n=3; indices 0 and 4 = 32'h2D413CCD real; k=2 -> o_expval = 0. k=0 -> o_expval = o_prob_sum, within 4 LSB of 2^30.
- n=3, k=3 -> o_err pulse one cycle after start; o_state_ena never asserted; o_busy stays 0.
- i_start re-pulsed mid-sweep -> ignored, results unchanged. rst asserted in ISSUE -> all outputs 0 next cycle and no o_done. A fresh sweep then gives the correct result.
- n=1 (W=1, lanes 2-3 ignored) with garbage in lanes 2-3 -> only lanes 0-1 accumulated. RD_LATENCY=3 variant -> o_done at cycle 7.
